// File: rtl/xchk_pkg.sv
// Shared types and default widths for the XOR-checksum frame checker.
// Optional feature macro used by the checker: XCHK_ERRCNT_EN.
package xchk_pkg;

  localparam int unsigned XCHK_DATA_W = 32;
  localparam int unsigned XCHK_LEN_W  = 8;
  localparam int unsigned ERRCNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/xchk_accum.sv
// DATA_W-wide XOR accumulator register with synchronous clear.
module xchk_accum
  import xchk_pkg::*;
#(
  parameter int unsigned DATA_W = XCHK_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] acc
);

  // Clear wins over accumulate so a new frame always starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ d;
    end
  end

endmodule

// File: rtl/xor_checksum_checker.sv
// Receive-side XOR-checksum checker: accumulates LEN payload words, then
// compares the trailing checksum word and strobes a registered verdict.
// Define XCHK_ERRCNT_EN to add a saturating err_count output.
module xor_checksum_checker
  import xchk_pkg::*;
#(
  parameter int unsigned DATA_W = XCHK_DATA_W,
  parameter int unsigned LEN_W  = XCHK_LEN_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic                busy,
  output logic                done,
  output logic                ok,
  output logic                err,
  output logic [DATA_W-1:0]   acc_out
`ifdef XCHK_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  state_t             state;
  state_t             state_n;
  logic [LEN_W-1:0]   rem;
  logic [LEN_W-1:0]   rem_n;
  logic [DATA_W-1:0]  acc;
  logic               acc_clr;
  logic               acc_en;
  logic               ok_n;
  logic               err_n;
  logic               xfer;

  assign xfer    = in_valid && in_ready;
  assign acc_out = acc;

  xchk_accum #(
    .DATA_W(DATA_W)
  ) u_accum (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (acc_en),
    .d     (in_data),
    .acc   (acc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state, counter update and verdict decode.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          rem_n   = len;
          acc_clr = 1'b1;
          state_n = (len != '0) ? PAYLOAD : CHECK;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          acc_en = 1'b1;
          if (rem != '0) begin
            rem_n = rem - LEN_W'(1);
          end
          if (rem == LEN_W'(1)) begin
            state_n = CHECK;
          end
        end
      end
      CHECK: begin
        if (xfer) begin
          ok_n    = (in_data == acc);
          err_n   = (in_data != acc);
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered outputs derived from the upcoming state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem      <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ok       <= 1'b0;
      err      <= 1'b0;
    end else begin
      rem      <= rem_n;
      in_ready <= (state_n == PAYLOAD) || (state_n == CHECK);
      busy     <= (state_n != IDLE);
      done     <= (state_n == DONE);
      ok       <= ok_n;
      err      <= err_n;
    end
  end

`ifdef XCHK_ERRCNT_EN
  // Saturating count of failed frames; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_n && (err_count != '1)) begin
      err_count <= err_count + ERRCNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_xor_checksum_checker.sv
// Directed, table-driven bench for xor_checksum_checker.
module tb_xor_checksum_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        ok;
  logic        err;
  logic [31:0] acc_out;
`ifdef XCHK_ERRCNT_EN
  logic [15:0] err_count;
  logic [15:0] exp_errcnt = 16'd0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]       len;
    logic [2:0][31:0] word;
    logic [2:0][7:0]  gap;
    logic [7:0]       cs_gap;
    logic [31:0]      cs;
    logic [31:0]      exp_acc;
    logic             exp_ok;
  } vec_t;

  vec_t tbl [7];

  xor_checksum_checker dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .ok       (ok),
    .err      (err),
    .acc_out  (acc_out)
`ifdef XCHK_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] l,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input logic [7:0] g0, input logic [7:0] g1, input logic [7:0] g2,
                              input logic [7:0] cg, input logic [31:0] cs,
                              input logic [31:0] ea, input logic eo);
    vec_t v;
    v.len = l;
    v.word[0] = w0; v.word[1] = w1; v.word[2] = w2;
    v.gap[0] = g0;  v.gap[1] = g1;  v.gap[2] = g2;
    v.cs_gap = cg;
    v.cs = cs;
    v.exp_acc = ea;
    v.exp_ok = eo;
    return v;
  endfunction

  task automatic send_word(input logic [31:0] w, input int gap, input string tag);
    logic [31:0] prev;
    prev = acc_out;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      chk({tag, "_gap_acc_hold"}, acc_out, prev);
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_no_early_done"}, 32'(done), 32'd0);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_verdict(input logic exp_ok, input logic [31:0] exp_acc);
    chk("verdict_done", 32'(done), 32'd1);
    chk("verdict_ok", 32'(ok), 32'(exp_ok));
    chk("verdict_err", 32'(err), 32'(!exp_ok));
    chk("verdict_ready", 32'(in_ready), 32'd0);
    chk("verdict_acc", acc_out, exp_acc);
`ifdef XCHK_ERRCNT_EN
    if (!exp_ok) exp_errcnt++;
    chk("err_count", 32'(err_count), 32'(exp_errcnt));
`endif
    @(negedge clk);
    chk("post_done", 32'(done), 32'd0);
    chk("post_ok_err", 32'({ok, err}), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_acc_hold", acc_out, exp_acc);
  endtask

  task automatic run_frame(input vec_t v);
    @(negedge clk);
    start = 1'b1;
    len   = v.len;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_acc_clear", acc_out, 32'd0);
    for (int i = 0; i < 32'(v.len); i++) begin
      send_word(v.word[i], 32'(v.gap[i]), "payload");
    end
    send_word(v.cs, 32'(v.cs_gap), "checksum");
    check_verdict(v.exp_ok, v.exp_acc);
  endtask

  initial begin
    // len, w0, w1, w2, gaps, cs gap, checksum, expected acc, expected ok
    tbl[0] = mk(8'd2, 32'h0000FFFF, 32'hFFFF0000, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0,
                32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    tbl[1] = mk(8'd2, 32'h0000FFFF, 32'hFFFF0000, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0,
                32'hFFFFFFFE, 32'hFFFFFFFF, 1'b0);
    tbl[2] = mk(8'd0, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0,
                32'h00000000, 32'h00000000, 1'b1);
    tbl[3] = mk(8'd0, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0,
                32'h00000001, 32'h00000000, 1'b0);
    // 12345678 ^ 0F0F0F0F ^ A5A5A5A5 = B89EFCD2
    tbl[4] = mk(8'd3, 32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5, 8'd0, 8'd2, 8'd5, 8'd0,
                32'hB89EFCD2, 32'hB89EFCD2, 1'b1);
    tbl[5] = mk(8'd3, 32'h12345678, 32'h0F0F0F0F, 32'hA5A5A5A5, 8'd0, 8'd2, 8'd5, 8'd0,
                32'hB8EEB8D2, 32'hB89EFCD2, 1'b0);
    tbl[6] = mk(8'd1, 32'hDEADBEEF, 32'h0, 32'h0, 8'd1, 8'd0, 8'd0, 8'd3,
                32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_ok_err", 32'({done, ok, err}), 32'd0);
    chk("rst_acc", acc_out, 32'd0);
`ifdef XCHK_ERRCNT_EN
    chk("rst_err_count", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 7; k++) begin
      run_frame(tbl[k]);
    end

    // start pulsed mid-frame must not reload the count or clear acc
    @(negedge clk);
    start = 1'b1;
    len   = 8'd2;
    @(negedge clk);
    start = 1'b0;
    send_word(32'h11110000, 0, "abuse");
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    chk("abuse_busy", 32'(busy), 32'd1);
    chk("abuse_acc_kept", acc_out, 32'h11110000);
    send_word(32'h00002222, 0, "abuse");
    send_word(32'h11112222, 0, "abuse_cs");
    check_verdict(1'b1, 32'h11112222);

    // reset after one of four words aborts the frame with no verdict
    @(negedge clk);
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    send_word(32'hCAFEF00D, 0, "rst_frame");
    chk("rst_frame_acc", acc_out, 32'hCAFEF00D);
    reset = 1'b1;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done_ok_err", 32'({done, ok, err}), 32'd0);
    chk("abort_acc", acc_out, 32'd0);
`ifdef XCHK_ERRCNT_EN
    exp_errcnt = 16'd0;
    chk("abort_err_count", 32'(err_count), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("abort_idle_no_done", 32'({done, busy}), 32'd0);
    end
    run_frame(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
